// File: rtl/pr_elastic.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pr_elastic
//  Brief    : Elastic pipeline stage register; DEPTH-entry circular buffer of
//             {pc, data} with valid/ready handshake, stall/flush and occupancy.
//  Revision : 1.0 - initial release
// ============================================================================
module pr_elastic #(
    parameter  int DATA_W = 96,
    parameter  int PC_W   = 32,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_stall,
    input  wire logic              i_flush,
    input  wire logic              in_valid,
    output logic                   in_ready,
    input  wire logic [PC_W-1:0]   in_pc,
    input  wire logic [DATA_W-1:0] in_data,
    output logic                   out_valid,
    input  wire logic              out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [DATA_W-1:0]      out_data,
    output logic [CNT_W-1:0]       count
);

    localparam int                 PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 ENT_W       = PC_W + DATA_W;
    localparam logic [CNT_W-1:0]   c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]   c_PTR_LAST  = PTR_W'(DEPTH - 1);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic             w_active;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_head;

    // Wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Handshake depends only on registered state and control, never on out_ready.
    assign w_active  = !rst && !i_stall && !i_flush;
    assign in_ready  = w_active && (count_q < c_DEPTH_CNT);
    assign out_valid = w_active && (count_q != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign w_head   = mem_q[rd_ptr_q];
    assign out_pc   = (count_q != '0) ? w_head[ENT_W-1:DATA_W] : '0;
    assign out_data = (count_q != '0) ? w_head[DATA_W-1:0]     : '0;
    assign count    = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (!i_stall) begin
            if (w_push) begin
                wr_ptr_d = f_inc(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_d = f_inc(rd_ptr_q);
            end
            if (w_push && !w_pop) begin
                count_d = count_q + 1'b1;
            end else if (w_pop && !w_push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is not reset; stale entries are masked by count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {in_pc, in_data};
        end
    end

`ifndef SYNTHESIS
    a_count_bound : assert property (@(posedge clk) disable iff (rst)
        count_q <= c_DEPTH_CNT);
    a_push_ready  : assert property (@(posedge clk) disable iff (rst)
        w_push |-> in_ready);
    a_pop_valid   : assert property (@(posedge clk) disable iff (rst)
        w_pop |-> out_valid);
    a_head_stable : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> $stable(out_data));
`endif

endmodule
`default_nettype wire

// File: tb/tb_pr_elastic.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pr_elastic
//  Brief    : Directed self-checking bench for pr_elastic (DEPTH=2 and DEPTH=1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pr_elastic;

    logic        clk = 1'b0;
    logic        rst;
    int          n_pass  = 0;
    int          n_total = 0;

    // DEPTH=2 instance signals
    logic        a_stall, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_pc, a_out_pc;
    logic [95:0] a_in_data, a_out_data;
    logic [1:0]  a_count;

    // DEPTH=1 instance signals
    logic        b_stall, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_pc, b_out_pc;
    logic [95:0] b_in_data, b_out_data;
    logic [0:0]  b_count;

    always #5 clk = ~clk;

    pr_elastic #(.DATA_W(96), .PC_W(32), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .i_stall(a_stall), .i_flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pc(a_in_pc), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc),
        .out_data(a_out_data), .count(a_count)
    );

    pr_elastic #(.DATA_W(96), .PC_W(32), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_stall(b_stall), .i_flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pc(b_in_pc), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
        .out_data(b_out_data), .count(b_count)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] dat(input int i);
        return 96'hC0DE_0000_0000_0000_0000_0000 + 96'(i * 3);
    endfunction

    initial begin
        rst = 1'b1;
        a_stall = 0; a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_pc = '0; a_in_data = '0;
        b_stall = 0; b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_pc = '0; b_in_data = '0;

        // Reset held for three cycles
        step();
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        repeat (2) step();
        rst = 1'b0;
        #1;
        chk("post_rst_count", a_count, 0);
        chk("post_rst_out_valid", a_out_valid, 0);
        chk("post_rst_out_data", a_out_data, 0);
        chk("post_rst_in_ready", a_in_ready, 1);
        chk("post_rst_in_ready_d1", b_in_ready, 1);

        // Fill to full with downstream stalled, then drain in order
        a_in_valid = 1; a_in_pc = 32'h100; a_in_data = dat(0);
        step();
        a_in_pc = 32'h104; a_in_data = dat(1);
        #1;
        chk("fill1_count", a_count, 1);
        chk("fill1_out_valid", a_out_valid, 1);
        chk("fill1_out_pc", a_out_pc, 32'h100);
        step();
        a_in_valid = 0;
        #1;
        chk("full_count", a_count, 2);
        chk("full_in_ready", a_in_ready, 0);
        chk("full_out_data", a_out_data, dat(0));
        a_out_ready = 1;
        #1;
        chk("drain0_pc", a_out_pc, 32'h100);
        chk("drain0_valid", a_out_valid, 1);
        step();
        chk("drain1_pc", a_out_pc, 32'h104);
        chk("drain1_data", a_out_data, dat(1));
        chk("drain1_count", a_count, 1);
        step();
        chk("empty_count", a_count, 0);
        chk("empty_out_valid", a_out_valid, 0);
        chk("empty_out_data", a_out_data, 0);
        a_out_ready = 0;

        // Stall at count=2 holds everything; flush overrides stall
        a_in_valid = 1; a_in_pc = 32'h100; a_in_data = dat(0);
        step();
        a_in_pc = 32'h104; a_in_data = dat(1);
        step();
        a_in_pc = 32'h108; a_in_data = dat(2);
        a_stall = 1; a_out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("stall_count", a_count, 2);
            chk("stall_head", a_out_pc, 32'h100);
            chk("stall_out_valid", a_out_valid, 0);
            chk("stall_in_ready", a_in_ready, 0);
            step();
        end
        a_flush = 1;
        #1;
        chk("flush_in_ready", a_in_ready, 0);
        step();
        a_stall = 0; a_flush = 0; a_in_valid = 0; a_out_ready = 0;
        #1;
        chk("flush_count", a_count, 0);
        chk("flush_out_data", a_out_data, 0);
        chk("flush_out_valid", a_out_valid, 0);

        // Streaming 20 payloads with wraparound
        a_out_ready = 1; a_in_valid = 1;
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) begin
                a_in_pc = 32'(i * 4); a_in_data = dat(i);
            end else begin
                a_in_valid = 0;
            end
            #1;
            if (i == 0) begin
                chk("stream_first_valid", a_out_valid, 0);
                chk("stream_first_count", a_count, 0);
            end else begin
                chk("stream_valid", a_out_valid, 1);
                chk("stream_pc", a_out_pc, 32'((i - 1) * 4));
                chk("stream_data", a_out_data, dat(i - 1));
                chk("stream_count", a_count, 1);
            end
            if (i < 20) chk("stream_in_ready", a_in_ready, 1);
            step();
        end
        chk("stream_end_count", a_count, 0);
        a_out_ready = 0;

        // DEPTH=1: one payload every other cycle
        b_in_valid = 1; b_out_ready = 1;
        for (int k = 0; k < 8; k++) begin
            b_in_pc = 32'h200 + 32'(4 * ((k + 1) / 2));
            b_in_data = dat(k);
            #1;
            chk("d1_count", b_count, k % 2);
            chk("d1_in_ready", b_in_ready, (k % 2) == 0);
            chk("d1_out_valid", b_out_valid, k % 2);
            if (k % 2 == 1) chk("d1_out_pc", b_out_pc, 32'h200 + 32'(4 * (k / 2)));
            step();
        end
        b_in_valid = 0; b_out_ready = 0;
        chk("d1_end_count", b_count, 0);

        // Reset mid-stream with two entries and in_valid high
        a_in_valid = 1; a_in_pc = 32'h300; a_in_data = dat(30);
        step();
        a_in_pc = 32'h304; a_in_data = dat(31);
        step();
        chk("pre_rst_count", a_count, 2);
        a_in_pc = 32'h308; a_in_data = dat(32);
        rst = 1;
        #1;
        chk("midrst_in_ready", a_in_ready, 0);
        chk("midrst_out_valid", a_out_valid, 0);
        step();
        rst = 0;
        #1;
        chk("rst2_count", a_count, 0);
        chk("rst2_out_pc", a_out_pc, 0);
        chk("rst2_out_data", a_out_data, 0);
        chk("rst2_out_valid", a_out_valid, 0);
        a_in_valid = 0;
        step();
        chk("rst2_idle_count", a_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
